// File: rtl/jtframe_mr_ddrload_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_mr_ddrload_if
//  Purpose  : Bundles the control, DDR burst-read and byte-programming
//             signals of the DDR ROM loader.
//  Modports : master - the loader (drives ddrld_* requests and prog_* bytes)
//             slave  - the environment (DDR mux, SDRAM download, control)
//  Signals  : dl_start/dl_len/busy/done          load control
//             ddrld_burstcnt/addr/rd/busy         Avalon-style read request
//             ddr_dout/ddr_dout_ready             read data return
//             prog_addr/prog_data/prog_we/ack     byte stream out
//  Revision : 1.0 - initial release
// ============================================================================
interface jtframe_mr_ddrload_if;
    logic        dl_start;
    logic [26:0] dl_len;
    logic        busy;
    logic        done;
    logic [7:0]  ddrld_burstcnt;
    logic [28:0] ddrld_addr;
    logic        ddrld_rd;
    logic        ddrld_busy;
    logic [63:0] ddr_dout;
    logic        ddr_dout_ready;
    logic [26:0] prog_addr;
    logic [7:0]  prog_data;
    logic        prog_we;
    logic        prog_ack;

    modport master (
        input  dl_start, dl_len, ddrld_busy, ddr_dout, ddr_dout_ready, prog_ack,
        output busy, done, ddrld_burstcnt, ddrld_addr, ddrld_rd,
               prog_addr, prog_data, prog_we
    );

    modport slave (
        output dl_start, dl_len, ddrld_busy, ddr_dout, ddr_dout_ready, prog_ack,
        input  busy, done, ddrld_burstcnt, ddrld_addr, ddrld_rd,
               prog_addr, prog_data, prog_we
    );
endinterface
`default_nettype wire

// File: rtl/jtframe_mr_ddrload.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_mr_ddrload
//  Purpose  : Reads a ROM image from DDR in bursts of 64-bit words, buffers
//             each burst and replays it byte by byte (little-endian) on the
//             programming interface.
//  Params   : BASE  - DDR word address of the image's first byte
//             BURST - maximum words per burst (1..32)
//  Ports    : clk   - system clock (shared with the DDR mux side)
//             rst   - asynchronous active-high reset
//             bus   - jtframe_mr_ddrload_if.master (control, DDR, prog)
//  Revision : 1.0 - initial release
// ============================================================================
module jtframe_mr_ddrload #(
    parameter logic [28:0] BASE  = 29'h0600_0000,
    parameter int          BURST = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    jtframe_mr_ddrload_if.master    bus
);

    localparam int         AW     = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [7:0] BURST8 = 8'(BURST);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]  state;
    logic [26:0] left;          // bytes still to emit
    logic [26:0] byte_ptr;      // next byte address to emit
    logic [28:0] word_offset;   // word offset of the current burst from BASE
    logic [5:0]  wcnt;          // words received in the current burst
    logic [8:0]  dcnt;          // byte index within the current burst
    logic [63:0] mem [0:(1<<AW)-1];

    // Words for the next burst: min(BURST, ceil(n/8)), 28-bit arithmetic
    function automatic logic [7:0] burst_words(input logic [26:0] n);
        logic [27:0] w;
        w = ({1'b0, n} + 28'd7) >> 3;
        if (w > {20'd0, BURST8})
            return BURST8;
        else
            return w[7:0];
    endfunction

    logic [5:0]  wcnt_inc;
    logic        burst_full;
    logic [8:0]  dcnt_next;
    logic [26:0] left_next;
    logic        last_byte;
    logic [28:0] wo_next;
    logic [63:0] next_word;
    logic [7:0]  next_byte;
    logic [7:0]  first_byte;

    always_comb begin
        wcnt_inc   = wcnt + 6'd1;
        burst_full = ({2'b0, wcnt_inc} == bus.ddrld_burstcnt);
        dcnt_next  = dcnt + 9'd1;
        left_next  = left - 27'd1;
        last_byte  = ({2'b0, dcnt_next} == {bus.ddrld_burstcnt, 3'b000}) ||
                     (left_next == 27'd0);
        wo_next    = word_offset + {21'd0, bus.ddrld_burstcnt};
        next_word  = mem[dcnt_next[AW+2:3]];
        next_byte  = 8'(next_word >> {dcnt_next[2:0], 3'b000});
        // A one-word burst completes on the very cycle word 0 arrives, so
        // the first byte must bypass the buffer in that case.
        first_byte = (wcnt == 6'd0) ? bus.ddr_dout[7:0] : mem[0][7:0];
    end

    // Burst buffer: contents are don't-care across reset
    always_ff @(posedge clk) begin
        if (state == DATA && bus.ddr_dout_ready)
            mem[wcnt[AW-1:0]] <= bus.ddr_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            left               <= 27'd0;
            byte_ptr           <= 27'd0;
            word_offset        <= 29'd0;
            wcnt               <= 6'd0;
            dcnt               <= 9'd0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.ddrld_rd       <= 1'b0;
            bus.ddrld_addr     <= BASE;
            bus.ddrld_burstcnt <= BURST8;
            bus.prog_we        <= 1'b0;
            bus.prog_addr      <= 27'd0;
            bus.prog_data      <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dl_start) begin
                        left        <= bus.dl_len;
                        byte_ptr    <= 27'd0;
                        word_offset <= 29'd0;
                        bus.busy    <= 1'b1;
                        if (bus.dl_len == 27'd0) begin
                            state <= DONE;
                        end else begin
                            state              <= REQ;
                            bus.ddrld_rd       <= 1'b1;
                            bus.ddrld_addr     <= BASE;
                            bus.ddrld_burstcnt <= burst_words(bus.dl_len);
                        end
                    end
                end
                REQ: begin
                    if (!bus.ddrld_busy) begin
                        bus.ddrld_rd <= 1'b0;
                        wcnt         <= 6'd0;
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (bus.ddr_dout_ready) begin
                        wcnt <= wcnt_inc;
                        if (burst_full) begin
                            state         <= DRAIN;
                            dcnt          <= 9'd0;
                            bus.prog_we   <= 1'b1;
                            bus.prog_addr <= byte_ptr;
                            bus.prog_data <= first_byte;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.prog_ack) begin
                        byte_ptr <= byte_ptr + 27'd1;
                        left     <= left_next;
                        if (last_byte) begin
                            bus.prog_we <= 1'b0;
                            word_offset <= wo_next;
                            if (left_next == 27'd0) begin
                                // done is raised here so it lands the cycle
                                // right after the final ack
                                bus.done <= 1'b1;
                                bus.busy <= 1'b0;
                                state    <= DONE;
                            end else begin
                                state              <= REQ;
                                bus.ddrld_rd       <= 1'b1;
                                bus.ddrld_addr     <= BASE + wo_next;
                                bus.ddrld_burstcnt <= burst_words(left_next);
                            end
                        end else begin
                            dcnt          <= dcnt_next;
                            bus.prog_addr <= byte_ptr + 27'd1;
                            bus.prog_data <= next_byte;
                        end
                    end
                end
                DONE: begin
                    // Entered with done already high after a real load, or
                    // low for a zero-length load which pulses it one cycle later
                    if (bus.done) begin
                        bus.done <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_mr_ddrload.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtframe_mr_ddrload
//  Purpose  : Self-checking bench for jtframe_mr_ddrload: DDR burst model,
//             byte and request scoreboards, handshake stability monitors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_mr_ddrload;

    localparam logic [28:0] BASE  = 29'h0600_0000;
    localparam int          BURST = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtframe_mr_ddrload_if bus ();

    jtframe_mr_ddrload #(.BASE(BASE), .BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int passed = 0;
    int total  = 0;

    logic [63:0] img [0:63];
    logic [34:0] exp_q [$];     // {prog_addr, prog_data}
    logic [36:0] req_q [$];     // {ddrld_addr, ddrld_burstcnt}
    int          writes = 0;
    int          reqs   = 0;
    int          ack_mode = 1;  // 0: never, 1: always, 2: 30% random

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected bytes and requests for a load of len bytes from img
    task automatic push_image(input int len);
        int off, rem, w;
        for (int i = 0; i < len; i++) begin
            logic [63:0] wd;
            wd = img[i / 8];
            exp_q.push_back({27'(i), 8'(wd >> (8 * (i % 8)))});
        end
        off = 0;
        rem = len;
        while (rem > 0) begin
            w = (rem + 7) / 8;
            if (w > BURST) w = BURST;
            req_q.push_back({BASE + 29'(off), 8'(w)});
            off += w;
            rem -= (rem < w * 8) ? rem : w * 8;
        end
    endtask

    task automatic start(input int len);
        @(posedge clk); #1;
        bus.dl_start = 1'b1;
        bus.dl_len   = 27'(len);
        @(posedge clk); #1;
        bus.dl_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("busy_at_done", 64'(bus.busy), 64'd0);
            @(negedge clk);
            check("done_one_cycle", 64'(bus.done), 64'd0);
        end
    endtask

    task automatic end_of_run(input int len);
        check("bytes_pending", 64'(exp_q.size()), 64'd0);
        check("reqs_pending", 64'(req_q.size()), 64'd0);
        check("write_count", 64'(writes), 64'(len));
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) img[i] = {$urandom, $urandom};
    endtask

    // prog_ack driver
    initial begin
        bus.prog_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ack_mode)
                0:       bus.prog_ack = 1'b0;
                1:       bus.prog_ack = 1'b1;
                default: bus.prog_ack = ($urandom_range(0, 99) < 30);
            endcase
        end
    end

    // DDR model: checks each accepted request and returns its words
    logic [28:0] f_addr;
    logic [7:0]  f_cnt;
    initial begin
        bus.ddr_dout_ready = 1'b0;
        bus.ddr_dout       = 64'd0;
        forever begin
            @(negedge clk);
            if (!rst && bus.ddrld_rd && !bus.ddrld_busy) begin
                f_addr = bus.ddrld_addr;
                f_cnt  = bus.ddrld_burstcnt;
                reqs++;
                if (req_q.size() == 0) begin
                    check("req_expected", 64'(req_q.size() != 0), 64'd1);
                end else begin
                    logic [36:0] e;
                    e = req_q.pop_front();
                    check("req_addr", 64'(f_addr), 64'(e[36:8]));
                    check("req_burstcnt", 64'(f_cnt), 64'(e[7:0]));
                end
                @(posedge clk); #1;
                for (int i = 0; i < int'(f_cnt); i++) begin
                    int idx;
                    idx = int'(f_addr - BASE) + i;
                    bus.ddr_dout       = (idx < 64) ? img[idx] : 64'd0;
                    bus.ddr_dout_ready = 1'b1;
                    @(posedge clk); #1;
                end
                bus.ddr_dout_ready = 1'b0;
            end
        end
    end

    // Byte scoreboard and handshake stability monitor
    logic        we_hold = 1'b0, rd_hold = 1'b0;
    logic [26:0] h_paddr;
    logic [7:0]  h_pdata;
    logic [28:0] h_raddr;
    logic [7:0]  h_rcnt;
    always @(negedge clk) begin
        if (rst) begin
            we_hold = 1'b0;
            rd_hold = 1'b0;
        end else begin
            if (we_hold) begin
                check("we_hold", 64'(bus.prog_we), 64'd1);
                check("addr_hold", 64'(bus.prog_addr), 64'(h_paddr));
                check("data_hold", 64'(bus.prog_data), 64'(h_pdata));
            end
            if (rd_hold) begin
                check("rd_hold", 64'(bus.ddrld_rd), 64'd1);
                check("raddr_hold", 64'(bus.ddrld_addr), 64'(h_raddr));
                check("rcnt_hold", 64'(bus.ddrld_burstcnt), 64'(h_rcnt));
            end
            if (bus.prog_we && bus.prog_ack) begin
                writes++;
                if (exp_q.size() == 0) begin
                    check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                end else begin
                    logic [34:0] e;
                    e = exp_q.pop_front();
                    check("prog_addr", 64'(bus.prog_addr), 64'(e[34:8]));
                    check("prog_data", 64'(bus.prog_data), 64'(e[7:0]));
                end
            end
            we_hold = bus.prog_we && !bus.prog_ack;
            h_paddr = bus.prog_addr;
            h_pdata = bus.prog_data;
            rd_hold = bus.ddrld_rd && bus.ddrld_busy;
            h_raddr = bus.ddrld_addr;
            h_rcnt  = bus.ddrld_burstcnt;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_rd", 64'(bus.ddrld_rd), 64'd0);
        check("rst_addr", 64'(bus.ddrld_addr), 64'(BASE));
        check("rst_burstcnt", 64'(bus.ddrld_burstcnt), 64'(BURST));
        check("rst_we", 64'(bus.prog_we), 64'd0);
        check("rst_paddr", 64'(bus.prog_addr), 64'd0);
        check("rst_pdata", 64'(bus.prog_data), 64'd0);
    endtask

    int r0;
    initial begin
        bus.dl_start   = 1'b0;
        bus.dl_len     = 27'd0;
        bus.ddrld_busy = 1'b0;
        fill_random();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;

        // Single short image
        img[0] = 64'hAABB_CC55_4433_2211;
        writes = 0;
        push_image(5);
        start(5);
        @(negedge clk);
        check("start_busy", 64'(bus.busy), 64'd1);
        check("start_rd", 64'(bus.ddrld_rd), 64'd1);
        wait_done(100);
        end_of_run(5);

        // Multi-burst: 300 bytes = 16 + 16 + 6 words
        fill_random();
        writes = 0;
        r0 = reqs;
        push_image(300);
        start(300);
        wait_done(1000);
        end_of_run(300);
        check("multi_req_count", 64'(reqs - r0), 64'd3);

        // Waitrequest held for 7 cycles in REQ
        fill_random();
        writes = 0;
        r0 = reqs;
        bus.ddrld_busy = 1'b1;
        push_image(20);
        start(20);
        repeat (7) @(posedge clk);
        #1;
        bus.ddrld_busy = 1'b0;
        wait_done(200);
        end_of_run(20);
        check("wait_req_count", 64'(reqs - r0), 64'd1);

        // Backpressure: 30% ack duty
        fill_random();
        writes = 0;
        ack_mode = 2;
        push_image(100);
        start(100);
        wait_done(3000);
        end_of_run(100);
        ack_mode = 1;

        // Zero length
        r0 = reqs;
        start(0);
        @(negedge clk);
        check("zero_busy", 64'(bus.busy), 64'd1);
        check("zero_done_early", 64'(bus.done), 64'd0);
        @(negedge clk);
        check("zero_done", 64'(bus.done), 64'd1);
        check("zero_busy_low", 64'(bus.busy), 64'd0);
        check("zero_no_rd", 64'(reqs - r0), 64'd0);

        // Abort mid-DRAIN, then restart
        fill_random();
        writes = 0;
        push_image(300);
        start(300);
        for (int i = 0; i < 500 && writes < 20; i++) @(negedge clk);
        check("abort_reached_drain", 64'(writes >= 20), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        exp_q.delete();
        req_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        writes = 0;
        push_image(5);
        start(5);
        wait_done(100);
        end_of_run(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtframe_mr_ddrload.md
# jtframe_mr_ddrload

Fetches a ROM image that the MiSTer HPS has placed in DDR and replays it byte by byte on the core's programming interface. It issues Avalon-style burst reads on the `ddrld_*` side of the MiSTer DDR multiplexer, buffers each burst and drains it as byte writes toward the SDRAM download logic. This gives a fast ROM load path in place of the slow `ioctl` byte stream.

## Interface
Parameters:
- `BASE`, 29'h0600_0000: DDR 64-bit word address of the image's first byte.
- `BURST`, 16: maximum words per burst, 1..32.

Ports:
- `clk` in 1: system clock; the DDR mux side uses the same clock while loading.
- `rst` in 1: reset, asynchronous, active-high.
- `dl_start` in 1: one-cycle start pulse.
- `dl_len` in 27: image length in bytes, sampled on `dl_start`.
- `busy` out 1: high from accepted start until `done`.
- `done` out 1: one-cycle pulse at end of load.
- `ddrld_burstcnt` out 8: words requested in the current burst.
- `ddrld_addr` out 29: DDR word address of the current burst.
- `ddrld_rd` out 1: read request.
- `ddrld_busy` in 1: waitrequest.
- `ddr_dout` in 64: read data.
- `ddr_dout_ready` in 1: read data valid.
- `prog_addr` out 27: byte address, counted from 0.
- `prog_data` out 8: byte.
- `prog_we` out 1: byte valid.
- `prog_ack` in 1: byte consumed.

## Operation
- States: IDLE, REQ, DATA, DRAIN, DONE.
- **IDLE**
  - `dl_start` latches `dl_len` into `left` (bytes remaining), clears the byte pointer and the word address offset, and sets `busy`.
  - If `dl_len==0`, go to DONE. Otherwise go to REQ.
  - `dl_start` is ignored outside IDLE.
- **REQ**
  - `ddrld_burstcnt = min(BURST, ceil(left/8))`. Compute `ceil` as `(left+7)>>3` using 28-bit arithmetic.
  - `ddrld_addr = BASE + word_offset`.
  - `ddrld_rd` stays high until a cycle with `ddrld_rd & ~ddrld_busy`. In that cycle the request is accepted: go to DATA.
  - `ddrld_addr` and `ddrld_burstcnt` are stable while `ddrld_rd` is high.
- **DATA**
  - Each `ddr_dout_ready` writes `ddr_dout` into buffer slot `wcnt` and increments `wcnt`.
  - When `wcnt` reaches `ddrld_burstcnt`, go to DRAIN.
  - `ddr_dout_ready` pulses outside DATA are discarded.
- **DRAIN**
  - Bytes are emitted little-endian: word k byte j is `buf[k][8j+7:8j]`, `prog_addr = byte_ptr`.
  - `prog_we` stays high with stable `prog_addr`/`prog_data` until `prog_ack`.
  - On ack: `byte_ptr+1`, `left-1`.
  - After the last byte of the burst, or when `left` reaches 0, do the following:
    - Add `ddrld_burstcnt` to `word_offset`.
    - If `left==0`, go to DONE. Otherwise go to REQ.
  - Bytes past `dl_len` in the last word are never emitted.
- **DONE**
  - `done=1` for one cycle, `busy` drops in the same cycle, then go to IDLE.
- **Reset mid-operation**: immediate return to IDLE. All outputs take their reset values. The buffer contents are don't-care.
- **Output reset values**:
  - `busy=0`, `done=0`, `ddrld_rd=0`, `ddrld_addr=BASE`, `ddrld_burstcnt=BURST`.
  - `prog_we=0`, `prog_addr=0`, `prog_data=0`.

## Timing
- All outputs are registered.
- `dl_start` at cycle n: `busy` is high at n+1, and `ddrld_rd` is high at n+1 for nonzero length.
- Request accepted at cycle m (`ddrld_busy` low): `ddrld_rd` is low at m+1.
- Last `ddr_dout_ready` at cycle d: the first `prog_we` is high at d+1.
- `prog_ack` at cycle a:
  - Next byte presented at a+1, with `prog_we` remaining high (one byte per cycle sustained when `prog_ack` is tied high).
  - After the burst's last byte, `ddrld_rd` is high at a+1.
- Last ack at cycle e: `done` at e+1, `busy` low at e+1.
- `ddrld_busy` has no effect outside REQ.

## Test plan
- **Single short image**: `dl_len=5`, bytes 0x11..0x55 in DDR word 0 at BASE, `ddrld_busy=0`, `prog_ack` tied high.
  - One request with `burstcnt=1`.
  - `prog_addr` 0..4 with data 0x11,0x22,0x33,0x44,0x55, then one `done` pulse.
  - Exactly 5 writes.
- **Multi-burst**: `BURST=16`, `dl_len=300` (38 words).
  - Requests at BASE, BASE+16, BASE+32 with burstcnt 16, 16, 6.
  - 300 bytes in order with incrementing address, and no write for bytes 300..303.
- **Waitrequest**: `ddrld_busy` held high for 7 cycles during REQ.
  - `ddrld_rd`, `ddrld_addr` and `ddrld_burstcnt` stay stable throughout.
  - Exactly one request is accepted.
- **Backpressure**: `prog_ack` random 30% duty.
  - `prog_addr`/`prog_data` never change while `prog_we` is high without ack.
  - The final stream matches the DDR image.
- **Zero length and abort**:
  - `dl_len=0` gives `done` two cycles after `dl_start` with no `ddrld_rd`.
  - `rst` asserted mid-DRAIN: all outputs go to their reset values immediately, and a new `dl_start` restarts from `prog_addr=0` at BASE.
